// File: rtl/lector_adc_spi_pkg.sv
// Shared definitions for the ADC SPI reader and the sample-clock divider.
// Holds the FSM state encoding, the default frame geometry and the sample rate
// constants that the divider and the reader must agree on.
package lector_adc_spi_pkg;

  localparam int unsigned SYS_CLK_HZ     = 100_000_000;
  localparam int unsigned SAMPLE_RATE_HZ = 100;
  // System-clock cycles per sample period; the divider counts this many.
  localparam int unsigned SAMPLE_DIV     = SYS_CLK_HZ / SAMPLE_RATE_HZ;

  localparam int unsigned CLK_DIV_DEF    = 50;  // SCLK half-period in system cycles
  localparam int unsigned FRAME_BITS_DEF = 16;  // SCLK periods per frame
  localparam int unsigned N_BITS_DEF     = 12;  // data bits kept from each frame

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSetup = 2'd1,
    StShift = 2'd2,
    StDone  = 2'd3
  } state_e;

endpackage

// File: rtl/lector_adc_spi_detector_flanco.sv
// Two-flop synchronizer with rising-edge pulse for an asynchronous input.
// Ports:
//   i_clk  - system clock
//   i_rst  - asynchronous active-high reset
//   i_d    - asynchronous input
//   o_sync - synchronized copy of i_d (two cycles of latency)
//   o_rise - one-cycle pulse on each rising edge of o_sync
module lector_adc_spi_detector_flanco (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_sync,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/lector_adc_spi.sv
// Serial ADC reader (PmodAD1-style). Each rising edge of the slow sample clock
// starts one SPI frame: CS low, a CLK_DIV-cycle setup, FRAME_BITS SCLK periods,
// then the last N_BITS received bits are published with a one-cycle strobe.
// Ports:
//   Clck_in     - 100 MHz system clock
//   reset_Clock - asynchronous active-high reset
//   enable      - low aborts any frame and holds the block idle
//   sample_clk  - asynchronous sample clock, rising edge starts a frame
//   sdata       - asynchronous ADC serial data
//   cs_n, sclk  - SPI chip select (active low) and clock (idles high)
//   dato        - last completed sample; dato_valid pulses when it updates
//   busy        - frame in progress; overrun - sticky, edge arrived while busy
module lector_adc_spi
  import lector_adc_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV    = CLK_DIV_DEF,    // must be >= 2
  parameter int unsigned FRAME_BITS = FRAME_BITS_DEF,
  parameter int unsigned N_BITS     = N_BITS_DEF      // 2 .. FRAME_BITS
) (
  input  logic              Clck_in,
  input  logic              reset_Clock,
  input  logic              enable,
  input  logic              sample_clk,
  input  logic              sdata,
  output logic              cs_n,
  output logic              sclk,
  output logic [N_BITS-1:0] dato,
  output logic              dato_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  state_e            r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic [BIT_W-1:0]  r_bit, w_bit_next;
  logic              r_sclk, w_sclk_next;
  logic [N_BITS-1:0] r_shift, w_shift_next;
  logic [N_BITS-1:0] r_dato, w_dato_next;
  logic              r_overrun;

  logic w_start;
  logic w_sdata_sync;
  logic w_unused_sample_sync;
  logic w_unused_sdata_rise;

  lector_adc_spi_detector_flanco u_det_sample (
    .i_clk  (Clck_in),
    .i_rst  (reset_Clock),
    .i_d    (sample_clk),
    .o_sync (w_unused_sample_sync),
    .o_rise (w_start)
  );

  // The SCLK half-period is long against the two-cycle synchronizer delay, so
  // the synchronized value is already settled when SCLK rises.
  lector_adc_spi_detector_flanco u_det_sdata (
    .i_clk  (Clck_in),
    .i_rst  (reset_Clock),
    .i_d    (sdata),
    .o_sync (w_sdata_sync),
    .o_rise (w_unused_sdata_rise)
  );

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_bit_next   = r_bit;
    w_sclk_next  = r_sclk;
    w_shift_next = r_shift;
    w_dato_next  = r_dato;

    unique case (r_state)
      StIdle: begin
        if (w_start && enable) begin
          w_state_next = StSetup;
          w_cnt_next   = '0;
          w_bit_next   = '0;
          w_sclk_next  = 1'b1;
          w_shift_next = '0;
        end
      end
      StSetup: begin
        if (r_cnt == CNT_LAST) begin
          w_state_next = StShift;
          w_cnt_next   = '0;
          w_sclk_next  = 1'b0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      StShift: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_next = '0;
          if (r_sclk) begin
            // End of a high phase: either the frame is complete or SCLK falls.
            // r_bit counts completed periods so it never has to reach FRAME_BITS.
            if (r_bit == BIT_LAST) begin
              w_state_next = StDone;
              w_dato_next  = r_shift;
            end else begin
              w_sclk_next = 1'b0;
              w_bit_next  = r_bit + 1'b1;
            end
          end else begin
            w_sclk_next  = 1'b1;
            w_shift_next = {r_shift[N_BITS-2:0], w_sdata_sync};
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase

    // Dropping enable abandons the frame without publishing a sample.
    if (!enable && (r_state != StIdle)) begin
      w_state_next = StIdle;
      w_dato_next  = r_dato;
    end
  end

  always_ff @(posedge Clck_in or posedge reset_Clock) begin
    if (reset_Clock) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_sclk    <= 1'b1;
      r_shift   <= '0;
      r_dato    <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_bit   <= w_bit_next;
      r_sclk  <= w_sclk_next;
      r_shift <= w_shift_next;
      r_dato  <= w_dato_next;
      // DONE counts as busy, so an edge landing on it is also an overrun.
      if (w_start && (r_state != StIdle)) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign cs_n       = (r_state == StIdle) || (r_state == StDone);
  assign sclk       = (r_state == StShift) ? r_sclk : 1'b1;
  assign busy       = (r_state == StSetup) || (r_state == StShift);
  assign dato_valid = (r_state == StDone);
  assign dato       = r_dato;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_lector_adc_spi.sv
`timescale 1ns/1ps
module tb_lector_adc_spi;

  localparam int unsigned CD  = 50;
  localparam int unsigned FB  = 16;
  localparam int unsigned NB  = 12;
  localparam int unsigned LEN = CD * (1 + 2 * FB);  // cs low to DONE, in cycles

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic sample_clk = 1'b0;
  logic sdata = 1'b0;
  logic cs_n, sclk, dato_valid, busy, overrun;
  logic [NB-1:0] dato;

  logic enable_f = 1'b1;
  logic sample_clk_f = 1'b0;
  logic sdata_f = 1'b1;
  logic cs_n_f, sclk_f, dato_valid_f, busy_f, overrun_f;
  logic [NB-1:0] dato_f;

  lector_adc_spi u_dut (
    .Clck_in     (clk),
    .reset_Clock (rst),
    .enable      (enable),
    .sample_clk  (sample_clk),
    .sdata       (sdata),
    .cs_n        (cs_n),
    .sclk        (sclk),
    .dato        (dato),
    .dato_valid  (dato_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  lector_adc_spi #(.CLK_DIV(2)) u_fast (
    .Clck_in     (clk),
    .reset_Clock (rst),
    .enable      (enable_f),
    .sample_clk  (sample_clk_f),
    .sdata       (sdata_f),
    .cs_n        (cs_n_f),
    .sclk        (sclk_f),
    .dato        (dato_f),
    .dato_valid  (dato_valid_f),
    .busy        (busy_f),
    .overrun     (overrun_f)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // ADC: first bit on CS fall, next bit after each SCLK rise, junk while deselected.
  logic [15:0] next_word = 16'h0;
  logic [15:0] adc_w = 16'h0;
  int          adc_idx = 15;
  bit          adc_sel = 1'b0;
  logic        adc_sclk_prev = 1'b1;
  initial forever begin
    @(negedge clk);
    if (cs_n) begin
      adc_sel = 1'b0;
      sdata = 1'($urandom_range(0, 1));
    end else if (!adc_sel) begin
      adc_sel = 1'b1;
      adc_w = next_word;
      adc_idx = 15;
      sdata = adc_w[15];
    end else if (sclk && !adc_sclk_prev && adc_idx > 0) begin
      adc_idx = adc_idx - 1;
      sdata = adc_w[adc_idx];
    end
    adc_sclk_prev = sclk;
  end

  // Reference model: a frame is (start cycle, word); outputs follow from the offset.
  logic        h0 = 0, h1 = 0, h2 = 0, h3 = 0;  // sample_clk seen in cycles n..n-3
  bit          m_act = 0;
  int unsigned m_s = 0;
  logic [15:0] m_w = 0;
  logic [NB-1:0] m_dato = 0;
  logic        m_ovr = 0;
  int          m_vcnt = 0;
  initial forever begin : model
    logic e_cs, e_sclk, e_busy, e_valid, st;
    bit was_act;
    int unsigned o;
    @(negedge clk);
    e_cs = 1; e_sclk = 1; e_busy = 0; e_valid = 0; o = 0;
    if (rst) begin
      h0 = 0; h1 = 0; h2 = 0; h3 = 0;
      m_act = 0; m_dato = '0; m_ovr = 0;
    end else begin
      h3 = h2; h2 = h1; h1 = h0; h0 = sample_clk;
      o = cyc - m_s;
      if (m_act) begin
        if (o < CD) begin
          e_cs = 0; e_busy = 1;
        end else if (o < LEN) begin
          e_cs = 0; e_busy = 1;
          e_sclk = (((o - CD) / CD) % 2) == 1;
        end else begin
          e_valid = 1;
          m_dato = m_w[NB-1:0];
        end
      end
    end
    check("cs_n", cs_n, e_cs);
    check("sclk", sclk, e_sclk);
    check("busy", busy, e_busy);
    check("dato_valid", dato_valid, e_valid);
    check("dato", dato, m_dato);
    check("overrun", overrun, m_ovr);
    if (dato_valid) m_vcnt++;
    if (!rst) begin
      st = h2 & ~h3;
      was_act = m_act;
      if (st && was_act) m_ovr = 1;
      if (was_act && (o == LEN || !enable)) m_act = 0;
      if (st && enable && !was_act) begin
        m_act = 1;
        m_s = cyc + 1;
        m_w = next_word;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input int budget, output bit got, output int unsigned at);
    got = 0;
    at = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dato_valid) begin
        got = 1;
        at = cyc;
        break;
      end
    end
  endtask

  // One frame; inj > 0 adds a second sample edge inj cycles after the first.
  task automatic frame(input logic [15:0] w, input int inj, output int unsigned lat);
    int unsigned c0, at;
    bit got;
    next_word = w;
    c0 = cyc;
    sample_clk = 1;
    step(20);
    sample_clk = 0;
    if (inj > 0) begin
      step(inj - 20);
      sample_clk = 1;
      step(10);
      sample_clk = 0;
    end
    wait_valid(2000, got, at);
    check("frame_valid_seen", got, 1);
    lat = at - c0;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int unsigned lat, c0, at, cs_at, r1, r2, v0;
    int nr, inj;
    bit got;
    logic sp;
    logic [15:0] w;

    step(3);
    check("rst_cs_n", cs_n, 1);
    check("rst_sclk", sclk, 1);
    check("rst_dato", dato, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    rst = 0;
    enable = 1;
    step(5);

    // Directed frame 0AC3: cs low 1 cycle after detect, valid 1651 after detect.
    next_word = 16'h0AC3;
    c0 = cyc;
    sample_clk = 1;
    cs_at = 0;
    for (int i = 0; i < 10 && cs_at == 0; i++) begin
      @(negedge clk);
      if (!cs_n) cs_at = cyc;
    end
    check("cs_latency", cs_at - c0, 3);
    step(20);
    sample_clk = 0;
    wait_valid(2000, got, at);
    check("first_valid_seen", got, 1);
    check("first_latency", at - c0, 1653);
    check("first_dato", dato, 12'hAC3);
    step(100);

    // Back-to-back frames FFF then 000.
    v0 = m_vcnt;
    frame(16'h0FFF, 0, lat);
    check("fff_latency", lat, 1653);
    check("fff_dato", dato, 12'hFFF);
    step(200);
    frame(16'h0000, 0, lat);
    check("zero_dato", dato, 12'h000);
    check("two_frames_valid_count", m_vcnt - v0, 2);
    check("two_frames_overrun", overrun, 0);
    step(50);

    // Enable low in idle: edge ignored, no overrun.
    enable = 0;
    v0 = m_vcnt;
    step(2);
    sample_clk = 1;
    step(20);
    sample_clk = 0;
    step(100);
    check("idle_dis_busy", busy, 0);
    check("idle_dis_overrun", overrun, 0);
    check("idle_dis_valid_count", m_vcnt - v0, 0);
    enable = 1;
    step(5);

    // Second edge 500 cycles into a frame.
    v0 = m_vcnt;
    frame(16'h0AC3, 500, lat);
    check("ovr_latency", lat, 1653);
    check("ovr_dato", dato, 12'hAC3);
    check("ovr_flag", overrun, 1);
    step(300);
    check("ovr_no_second_frame", m_vcnt - v0, 1);
    check("ovr_idle_after", busy, 0);

    // Enable dropped during bit 7.
    v0 = m_vcnt;
    next_word = 16'h0555;
    sample_clk = 1;
    step(20);
    sample_clk = 0;
    nr = 0;
    sp = sclk;
    for (int i = 0; i < 1500 && nr < 7; i++) begin
      @(negedge clk);
      if (sclk && !sp) nr++;
      sp = sclk;
    end
    check("abort_reached_bit7", nr, 7);
    step(10);
    enable = 0;
    @(negedge clk);
    @(negedge clk);
    check("abort_cs_n", cs_n, 1);
    check("abort_sclk", sclk, 1);
    check("abort_busy", busy, 0);
    step(1800);
    check("abort_no_valid", m_vcnt - v0, 0);
    check("abort_dato_kept", dato, 12'hAC3);
    enable = 1;
    step(5);

    // Random words, random gaps, occasional mid-frame second edge.
    for (int i = 0; i < 8; i++) begin
      w = 16'($urandom());
      inj = ($urandom_range(0, 2) == 0) ? int'($urandom_range(100, 1500)) : 0;
      frame(w, inj, lat);
      check("rand_latency", lat, 1653);
      check("rand_dato", dato, {20'h0, w[11:0]});
      step($urandom_range(5, 300));
    end

    // Asynchronous reset in the middle of SHIFT.
    next_word = 16'h0F0F;
    sample_clk = 1;
    step(20);
    sample_clk = 0;
    step(300);
    @(posedge clk);
    #3;
    rst = 1;
    #1;
    check("arst_cs_n", cs_n, 1);
    check("arst_sclk", sclk, 1);
    check("arst_dato", dato, 0);
    check("arst_busy", busy, 0);
    check("arst_overrun", overrun, 0);
    step(3);
    rst = 0;
    step(5);

    // Clean frame after reset, with a second edge landing on DONE.
    next_word = 16'h0123;
    c0 = cyc;
    sample_clk = 1;
    step(20);
    sample_clk = 0;
    step(1631);
    sample_clk = 1;
    wait_valid(100, got, at);
    check("post_rst_valid_seen", got, 1);
    check("post_rst_latency", at - c0, 1653);
    check("post_rst_dato", dato, 12'h123);
    step(20);
    sample_clk = 0;
    step(50);
    check("done_edge_overrun", overrun, 1);
    check("done_edge_no_frame", busy, 0);

    // CLK_DIV = 2 instance: 67 cycles detect to valid, SCLK period 4.
    c0 = cyc;
    sample_clk_f = 1;
    got = 0; at = 0; cs_at = 0; r1 = 0; r2 = 0; nr = 0; sp = 1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (!cs_n_f && cs_at == 0) cs_at = cyc;
      if (sclk_f && !sp) begin
        nr++;
        if (nr == 1) r1 = cyc;
        if (nr == 2) r2 = cyc;
      end
      sp = sclk_f;
      if (dato_valid_f) begin
        got = 1;
        at = cyc;
      end
    end
    sample_clk_f = 0;
    check("fast_valid_seen", got, 1);
    check("fast_cs_latency", cs_at - c0, 3);
    check("fast_sclk_period", r2 - r1, 4);
    check("fast_rises", nr, 16);
    check("fast_latency", at - c0, 69);
    check("fast_dato", dato_f, 12'hFFF);
    check("fast_overrun", overrun_f, 0);

    step(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
